// File: rtl/alu_pkg.sv
// Shared ALU operation encoding and helpers for the ALU controller and the execute-stage ALU.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD       = 4'd0,
    ALU_SUB       = 4'd1,
    ALU_AND       = 4'd2,
    ALU_OR        = 4'd3,
    ALU_XOR       = 4'd4,
    ALU_U_LOW_EQ  = 4'd5,
    ALU_S_LOW_EQ  = 4'd6,
    ALU_U_HIGH_EQ = 4'd7,
    ALU_S_HIGH_EQ = 4'd8,
    ALU_U_LOWER   = 4'd9,
    ALU_S_LOWER   = 4'd10,
    ALU_U_HIGHER  = 4'd11,
    ALU_S_HIGHER  = 4'd12,
    ALU_SLL       = 4'd13,
    ALU_SRL       = 4'd14,
    ALU_ILLEGAL   = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result valid-ready bus between the operand-mux stage and the execute ALU.
interface alu_exec_unit_if #(
  parameter int unsigned XLEN = 32
) ();

  logic               in_valid;
  logic               in_ready;
  alu_pkg::alu_op_e   alu_op;
  logic [XLEN-1:0]    op_a;
  logic [XLEN-1:0]    op_b;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    result;
  logic               zero;
  logic               illegal;

  modport master (
    output in_valid, alu_op, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_op, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );

endinterface

// File: rtl/alu_serial_shifter.sv
// Iterative logical shifter: one bit per cycle, direction and amount latched on load.
module alu_serial_shifter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            dir_right,
  input  logic [SHW-1:0]  amount,
  input  logic [XLEN-1:0] data_in,
  output logic            busy,
  output logic            done_c,
  output logic [XLEN-1:0] data_out
);

  logic [XLEN-1:0] data_q;
  logic [SHW-1:0]  cnt_q;
  logic            busy_q;
  logic            dir_q;

  // Counter runs down from the requested amount; done is flagged once it hits zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      dir_q  <= 1'b0;
    end else if (load) begin
      data_q <= data_in;
      cnt_q  <= amount;
      busy_q <= 1'b1;
      dir_q  <= dir_right;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        data_q <= dir_q ? (data_q >> 1) : (data_q << 1);
        cnt_q  <= cnt_q - SHW'(1);
      end
    end
  end

  assign busy     = busy_q;
  assign done_c   = busy_q && (cnt_q == '0);
  assign data_out = data_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare, iterative shifts, valid/ready in and out.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_exec_unit_if.slave        bus
);

  localparam int unsigned SHW = $clog2(XLEN);

  alu_state_e      state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  logic            accept_c;
  logic            sh_load_c;
  logic            sh_busy;
  logic            sh_done_c;
  logic [XLEN-1:0] sh_data;
  logic [XLEN-1:0] alu_res_c;

  // Held low during reset so nothing is accepted before the unit is live.
  assign bus.in_ready = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready));
  assign accept_c     = bus.in_valid && bus.in_ready;
  assign sh_load_c    = accept_c && is_shift(bus.alu_op);

  alu_serial_shifter #(.XLEN(XLEN), .SHW(SHW)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load_c),
    .dir_right (bus.alu_op == ALU_SRL),
    .amount    (bus.op_b[SHW-1:0]),
    .data_in   (bus.op_a),
    .busy      (sh_busy),
    .done_c    (sh_done_c),
    .data_out  (sh_data)
  );

  // Single-cycle datapath; the illegal code falls to the zero default.
  always_comb begin
    alu_res_c = '0;
    case (bus.alu_op)
      ALU_ADD:       alu_res_c = bus.op_a + bus.op_b;
      ALU_SUB:       alu_res_c = bus.op_a - bus.op_b;
      ALU_AND:       alu_res_c = bus.op_a & bus.op_b;
      ALU_OR:        alu_res_c = bus.op_a | bus.op_b;
      ALU_XOR:       alu_res_c = bus.op_a ^ bus.op_b;
      ALU_U_LOW_EQ:  alu_res_c = XLEN'(bus.op_a <= bus.op_b);
      ALU_S_LOW_EQ:  alu_res_c = XLEN'($signed(bus.op_a) <= $signed(bus.op_b));
      ALU_U_HIGH_EQ: alu_res_c = XLEN'(bus.op_a >= bus.op_b);
      ALU_S_HIGH_EQ: alu_res_c = XLEN'($signed(bus.op_a) >= $signed(bus.op_b));
      ALU_U_LOWER:   alu_res_c = XLEN'(bus.op_a < bus.op_b);
      ALU_S_LOWER:   alu_res_c = XLEN'($signed(bus.op_a) < $signed(bus.op_b));
      ALU_U_HIGHER:  alu_res_c = XLEN'(bus.op_a > bus.op_b);
      ALU_S_HIGHER:  alu_res_c = XLEN'($signed(bus.op_a) > $signed(bus.op_b));
      default:       alu_res_c = '0;
    endcase
  end

  // Next-state and output-register values; results only change on accept or shift completion.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if ((state_q == ST_DONE) && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
        if (accept_c) begin
          if (is_shift(bus.alu_op)) begin
            state_d     = ST_SHIFT;
            out_valid_d = 1'b0;
          end else begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            result_d    = alu_res_c;
            zero_d      = (alu_res_c == '0);
            illegal_d   = (bus.alu_op == ALU_ILLEGAL);
          end
        end
      end
      ST_SHIFT: begin
        if (sh_done_c) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          result_d    = sh_data;
          zero_d      = (sh_data == '0);
          illegal_d   = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_exec_unit_if #(.XLEN(XLEN)) bus ();

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one op just after an edge; it is accepted on the following edge.
  task automatic issue(input alu_op_e op, input logic [31:0] a, input logic [31:0] b, input string tag);
    check({tag, "/in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.op_a     = a;
    bus.op_b     = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int max, output int lat, output logic ready_seen);
    lat = 0;
    ready_seen = 1'b0;
    while (lat < max) begin
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid) return;
      if (bus.in_ready) ready_seen = 1'b1;
    end
    lat = -1;
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "/drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input logic exp_zero, input logic exp_ill,
                     input int exp_lat, input string tag);
    int   lat;
    logic rs;
    issue(op, a, b, tag);
    wait_out(40, lat, rs);
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/result"}, bus.result, exp_res);
    check({tag, "/zero"}, 32'(bus.zero), 32'(exp_zero));
    check({tag, "/illegal"}, 32'(bus.illegal), 32'(exp_ill));
    check({tag, "/busy_ready"}, 32'(rs), 32'd0);
    consume(tag);
  endtask

  initial begin
    int   lat;
    logic rs;
    logic seen;
    bus.in_valid  = 1'b0;
    bus.alu_op    = ALU_ADD;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b0;

    #12;
    check("rst/out_valid", 32'(bus.out_valid), 32'd0);
    check("rst/result", bus.result, 32'd0);
    check("rst/zero", 32'(bus.zero), 32'd0);
    check("rst/illegal", 32'(bus.illegal), 32'd0);
    check("rst/in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(ALU_ADD,       32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1,  "add");
    run(ALU_SUB,       32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1'b0, 1,  "sub");
    run(ALU_SUB,       32'd9,          32'd9,          32'd0,          1'b1, 1'b0, 1,  "sub_eq");
    run(ALU_AND,       32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0, 1'b0, 1,  "and");
    run(ALU_OR,        32'h0000_F0F0,  32'h0000_0F00,  32'h0000_FFF0,  1'b0, 1'b0, 1,  "or");
    run(ALU_S_LOWER,   32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0, 1,  "s_lower");
    run(ALU_U_LOWER,   32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 1,  "u_lower");
    run(ALU_S_HIGH_EQ, 32'h8000_0000,  32'h8000_0000,  32'd1,          1'b0, 1'b0, 1,  "s_high_eq");
    run(ALU_U_HIGHER,  32'h8000_0000,  32'd1,          32'd1,          1'b0, 1'b0, 1,  "u_higher");
    run(ALU_S_HIGHER,  32'h8000_0000,  32'd1,          32'd0,          1'b1, 1'b0, 1,  "s_higher");
    run(ALU_U_LOW_EQ,  32'd5,          32'd5,          32'd1,          1'b0, 1'b0, 1,  "u_low_eq");
    run(ALU_S_LOW_EQ,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0, 1,  "s_low_eq");
    run(ALU_SLL,       32'd1,          32'd31,         32'h8000_0000,  1'b0, 1'b0, 32, "sll31");
    run(ALU_SRL,       32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0, 1'b0, 5,  "srl4");
    run(ALU_SRL,       32'h0000_1234,  32'd0,          32'h0000_1234,  1'b0, 1'b0, 1,  "srl0");
    run(ALU_SLL,       32'd3,          32'h0000_0021,  32'd6,          1'b0, 1'b0, 2,  "sll_mask");

    // Backpressure followed by a same-cycle drain and accept.
    issue(ALU_XOR, 32'h0000_00F0, 32'h0000_00FF, "bp");
    wait_out(4, lat, rs);
    check("bp/latency", 32'(lat), 32'd1);
    check("bp/result", bus.result, 32'h0000_000F);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp/hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp/hold_result", bus.result, 32'h0000_000F);
      check("bp/hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("b2b/in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.alu_op   = ALU_ADD;
    bus.op_a     = 32'd1;
    bus.op_b     = 32'd1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b/out_valid", 32'(bus.out_valid), 32'd1);
    check("b2b/result", bus.result, 32'd2);
    consume("b2b");

    run(ALU_ILLEGAL,   32'd123,        32'd456,        32'd0,          1'b1, 1'b1, 1,  "illegal");
    run(ALU_ADD,       32'd0,          32'd0,          32'd0,          1'b1, 1'b0, 1,  "post_illegal");

    // Reset in the middle of a long shift must discard it.
    issue(ALU_SLL, 32'd1, 32'd20, "rst_shift");
    repeat (10) @(posedge clk);
    #1;
    check("rst_shift/busy_ready", 32'(bus.in_ready), 32'd0);
    check("rst_shift/busy_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_shift/out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_shift/in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_shift/idle_ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("rst_shift/no_partial", 32'(seen), 32'd0);
    run(ALU_ADD,       32'd2,          32'd3,          32'd5,          1'b0, 1'b0, 1,  "recover");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
